// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage.
// Optional feature macro: ALU_PARITY_FLAG_EN adds a parity flag to each entry.
package alu_pkg;

    localparam int DW  = 8;   // ALU result width
    localparam int RW  = 3;   // destination register index width
    localparam int OPW = 5;   // ALU opcode width

    // Bit positions inside the committed flag vector
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_P = 3;

`ifdef ALU_PARITY_FLAG_EN
    localparam int NFLAGS = 4;
`else
    localparam int NFLAGS = 3;
`endif

    // One buffered ALU result with the flags derived from it at capture time
    typedef struct packed {
        logic [DW-1:0]  data;
        logic [OPW-1:0] op;
        logic [RW-1:0]  dest;
        logic           c;
        logic           z;
        logic           n;
`ifdef ALU_PARITY_FLAG_EN
        logic           p;
`endif
        logic           flag_we;
    } alu_entry_t;

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer (main + skid) carrying alu_entry_t.
// in_ready is registered, so there is no combinational path from out_ready.
// Optional feature macro: ALU_PARITY_FLAG_EN (only widens alu_entry_t).
module alu_skid_buf
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  alu_entry_t in_entry,
    output logic       out_valid,
    input  logic       out_ready,
    output alu_entry_t out_entry
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t       state;
    alu_entry_t skid_entry;
    logic       accept;
    logic       transfer;
    logic       load_skid;

    assign accept    = in_valid & in_ready;
    assign transfer  = out_valid & out_ready;
    assign load_skid = (state == ONE) & accept & ~transfer;

    // Occupancy FSM: owns the main entry and the registered handshake outputs
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values, regardless of statement order.
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_entry <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_entry <= in_entry;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && transfer) begin
                        out_entry <= in_entry;
                    end else if (accept) begin
                        in_ready  <= 1'b0;
                        state     <= FULL;
                    end else if (transfer) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (transfer) begin
                        out_entry <= skid_entry;
                        in_ready  <= 1'b1;
                        state     <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Skid payload: captured when the main entry is held and a new result arrives
    always_ff @(posedge clk) begin
        // NOTE: skid payload is not reset; it is only read while the FSM says FULL, so its power-up value is never seen.
        if (load_skid) begin
            skid_entry <= in_entry;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Pipeline register after the 8-bit ALU: captures result/carry/dest under
// valid/ready through a 2-entry skid buffer and commits C/Z/N flags when an
// entry is handed to writeback.
// Optional feature macro: ALU_PARITY_FLAG_EN adds committed even-parity flag_p.
module alu_result_stage
    import alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [DW-1:0]  alu_dout,
    input  logic           alu_carry,
    input  logic [OPW-1:0] alu_op,
    input  logic [RW-1:0]  in_dest,
    input  logic           in_flag_we,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [DW-1:0]  out_data,
    output logic [OPW-1:0] out_op,
    output logic [RW-1:0]  out_dest,
    output logic           flag_c,
    output logic           flag_z,
`ifdef ALU_PARITY_FLAG_EN
    output logic           flag_p,
`endif
    output logic           flag_n
);

    alu_entry_t         cap_entry;
    alu_entry_t         head_entry;
    logic [NFLAGS-1:0]  flags;
    logic               transfer;

    // Build the entry to capture, deriving Z/N (and P) from the raw ALU result
    always_comb begin
        // NOTE: default the whole struct first so no field can infer a latch.
        cap_entry         = '0;
        cap_entry.data    = alu_dout;
        cap_entry.op      = alu_op;
        cap_entry.dest    = in_dest;
        cap_entry.c       = alu_carry;
        cap_entry.z       = (alu_dout == '0);
        cap_entry.n       = alu_dout[DW-1];
`ifdef ALU_PARITY_FLAG_EN
        cap_entry.p       = ^alu_dout;
`endif
        cap_entry.flag_we = in_flag_we;
    end

    alu_skid_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (cap_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (head_entry)
    );

    assign transfer = out_valid & out_ready;

    // Commit the head entry's flags to the architectural register on handoff
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= '0;
        end else if (transfer && head_entry.flag_we) begin
            flags[FLAG_C] <= head_entry.c;
            flags[FLAG_Z] <= head_entry.z;
            flags[FLAG_N] <= head_entry.n;
`ifdef ALU_PARITY_FLAG_EN
            flags[FLAG_P] <= head_entry.p;
`endif
        end
    end

    assign out_data = head_entry.data;
    assign out_op   = head_entry.op;
    assign out_dest = head_entry.dest;
    assign flag_c   = flags[FLAG_C];
    assign flag_z   = flags[FLAG_Z];
    assign flag_n   = flags[FLAG_N];
`ifdef ALU_PARITY_FLAG_EN
    assign flag_p   = flags[FLAG_P];
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
// Optional feature macro: ALU_PARITY_FLAG_EN enables the flag_p checks.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alu_dout;
    logic       alu_carry;
    logic [4:0] alu_op;
    logic [2:0] in_dest;
    logic       in_flag_we;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] out_op;
    logic [2:0] out_dest;
    logic       flag_c;
    logic       flag_z;
    logic       flag_n;
`ifdef ALU_PARITY_FLAG_EN
    logic       flag_p;
`endif

    int checks   = 0;
    int failures = 0;

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_dout   (alu_dout),
        .alu_carry  (alu_carry),
        .alu_op     (alu_op),
        .in_dest    (in_dest),
        .in_flag_we (in_flag_we),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_op     (out_op),
        .out_dest   (out_dest),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
`ifdef ALU_PARITY_FLAG_EN
        .flag_p     (flag_p),
`endif
        .flag_n     (flag_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one edge; outputs are then sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one ALU result; op and dest are derived from the data for easy checking
    task automatic drive(input logic v, input logic [7:0] d, input logic c, input logic we);
        in_valid   = v;
        alu_dout   = d;
        alu_carry  = c;
        alu_op     = d[4:0];
        in_dest    = d[2:0];
        in_flag_we = we;
    endtask

    task automatic check_flags(input string tag, input logic c, input logic z, input logic n);
        check({tag, "_c"}, 32'(flag_c), 32'(c));
        check({tag, "_z"}, 32'(flag_z), 32'(z));
        check({tag, "_n"}, 32'(flag_n), 32'(n));
    endtask

    initial begin
        // 1. Reset held two cycles while in_valid is asserted
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check_flags("rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // 2. Single result, one cycle latency
        out_ready = 1'b1;
        drive(1'b1, 8'h0C, 1'b0, 1'b1);
        tick();
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h0C);
        check("single_op", 32'(out_op), 32'h0C);
        check("single_dest", 32'(out_dest), 32'd4);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("single_drained", 32'(out_valid), 32'd0);
        check_flags("single", 1'b0, 1'b0, 1'b0);

        // 3. Backpressure fills main and skid, third result waits
        out_ready = 1'b0;
        drive(1'b1, 8'h01, 1'b0, 1'b0);
        tick();
        check("bp1_in_ready", 32'(in_ready), 32'd1);
        check("bp1_data", 32'(out_data), 32'h01);
        drive(1'b1, 8'h02, 1'b0, 1'b0);
        tick();
        check("bp2_in_ready", 32'(in_ready), 32'd0);
        drive(1'b1, 8'h03, 1'b0, 1'b0);
        tick();
        check("bp3_in_ready", 32'(in_ready), 32'd0);
        check("bp3_hold_data", 32'(out_data), 32'h01);
        check("bp3_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("bp_rel1_data", 32'(out_data), 32'h02);
        check("bp_rel1_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("bp_rel2_data", 32'(out_data), 32'h03);
        check("bp_rel2_valid", 32'(out_valid), 32'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check_flags("bp_no_we", 1'b0, 1'b0, 1'b0);

        // 4. Flag commit and flag_we=0 entries leaving flags alone
        drive(1'b1, 8'h00, 1'b1, 1'b1);
        tick();
        check_flags("flag_pre_commit", 1'b0, 1'b0, 1'b0);
        drive(1'b1, 8'h80, 1'b0, 1'b0);
        tick();
        check_flags("flag_commit1", 1'b1, 1'b1, 1'b0);
        check("flag_reload_data", 32'(out_data), 32'h80);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_flags("flag_we0", 1'b1, 1'b1, 1'b0);
        drive(1'b1, 8'h80, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_flags("flag_neg", 1'b0, 1'b0, 1'b1);

        // 5. Streaming one result per cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            tick();
            check($sformatf("stream%0d_data", i), 32'(out_data), 32'(i));
            check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // 6. Reset while FULL discards entries and clears flags (N currently 1)
        out_ready = 1'b0;
        drive(1'b1, 8'h07, 1'b1, 1'b1);
        tick();
        drive(1'b1, 8'h05, 1'b1, 1'b1);
        tick();
        check("mid_full_in_ready", 32'(in_ready), 32'd0);
        rst_n     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_flags("mid_rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("mid_rst_discarded", 32'(out_valid), 32'd0);

        // Commit 8'h07: odd number of ones so even-parity flag is 1
        drive(1'b1, 8'h07, 1'b0, 1'b1);
        tick();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check_flags("par_entry", 1'b0, 1'b0, 1'b0);
`ifdef ALU_PARITY_FLAG_EN
        check("par_flag_p", 32'(flag_p), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
